// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per clock, start/busy/done handshake
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    state_t                  r_state, w_next;
    logic [DIVIDEND_W-1:0]   r_dvd;
    logic [DIVISOR_W-1:0]    r_dvs;
    logic [DIVISOR_W:0]      r_prem;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_dbz;
    logic                    w_accept;
    logic                    w_zero;
    logic                    w_last;
    logic                    w_ge;
    logic [DIVISOR_W+1:0]    w_shift;
    logic [DIVISOR_W:0]      w_diff;
    // the dividend register doubles as the quotient: its MSB feeds the partial remainder while quotient bits enter at the LSB
    assign w_shift   = {r_prem, r_dvd[DIVIDEND_W-1]};
    assign w_ge      = w_shift >= {2'b00, r_dvs};
    assign w_diff    = w_shift[DIVISOR_W:0] - {1'b0, r_dvs};
    assign w_last    = r_cnt == CNT_W'(1);
    assign w_zero    = divisor == '0;
    assign w_accept  = (r_state == S_IDLE) && start;
    assign quotient  = r_dvd;
    assign remainder = r_prem[DIVISOR_W-1:0];
    assign div_by_zero = r_dbz;
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    // next state and handshake outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: w_next = start ? (w_zero ? S_DONE : S_CALC) : S_IDLE;
            S_CALC: begin
                busy   = 1'b1;
                w_next = w_last ? S_DONE : S_CALC;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    // operand capture and one shift/subtract/restore step per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
            r_cnt  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_dvs  <= divisor;
            r_cnt  <= CNT_W'(DIVIDEND_W);
            r_dbz  <= w_zero;
            r_dvd  <= w_zero ? '1 : dividend;
            r_prem <= w_zero ? {1'b0, dividend[DIVISOR_W-1:0]} : '0;
        end else if (r_state == S_CALC) begin
            r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_ge};
            r_prem <= w_ge ? w_diff : w_shift[DIVISOR_W:0];
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and random checks of the divider against plain-arithmetic expectations
module tb_seq_restoring_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    int          n_chk = 0;
    int          n_err = 0;

    seq_restoring_divider dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        eq = (b == 0) ? 16'hFFFF : a / {8'h00, b};
        er = (b == 0) ? a[7:0] : 8'(a % {8'h00, b});
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(b == 0));
        if (b != 0) begin
            chk({tag, "_recon"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk({tag, "_rlt"}, 32'(remainder < b), 1);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b);
        int n;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 1);
        wait_done(tag, n);
        chk({tag, "_lat"}, 32'(n + 1), (b == 0) ? 1 : 17);
        check_result(tag, a, b);
        tick();
        chk({tag, "_pulse"}, 32'(done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        check_result({tag, "_hold"}, a, b);
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] a;
        logic [7:0]  b;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        dividend = 16'h1234;
        divisor  = 8'h05;
        start    = 1'b1;
        tick();
        chk("rst_start_busy", 32'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_start_idle", 32'(busy), 0);

        run_op("basic", 16'h03E8, 8'h07);
        run_op("max", 16'hFFFF, 8'hFF);
        run_op("div1", 16'hFFFF, 8'h01);
        run_op("small", 16'h0003, 8'hC8);
        run_op("zero_dvd", 16'h0000, 8'h05);
        run_op("dbz", 16'h1234, 8'h00);
        run_op("after_dbz", 16'h0100, 8'h10);

        dividend = 16'h0064;
        divisor  = 8'h0A;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        dividend = 16'h00FF;
        divisor  = 8'h02;
        start    = 1'b1;
        tick();
        start = 1'b0;
        dividend = 16'h0064;
        divisor  = 8'h0A;
        wait_done("ignored", n);
        chk("ignored_lat", 32'(n + 6), 17);
        check_result("ignored", 16'h0064, 8'h0A);
        dividend = 16'h00FF;
        divisor  = 8'h02;
        start    = 1'b1;
        tick();
        chk("b2b_done_ignored", 32'(busy), 0);
        tick();
        chk("b2b_accept", 32'(busy), 1);
        start = 1'b0;
        wait_done("b2b", n);
        chk("b2b_lat", 32'(n + 1), 17);
        check_result("b2b", 16'h00FF, 8'h02);
        tick();

        dividend = 16'hABCD;
        divisor  = 8'h13;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_q", 32'(quotient), 0);
        chk("abort_r", 32'(remainder), 0);
        seen = 0;
        repeat (25) begin
            tick();
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 0);
        run_op("after_abort", 16'hABCD, 8'h13);

        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'h00;
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 300));
            run_op($sformatf("rnd%0d", i), a, b);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
